// File: rtl/kay_mem_pkg.sv
// -----------------------------------------------------------------------------
// kay_mem_pkg
// Shared definitions for the byte-addressed data memory:
//   - RV32 access-size encodings (byte / half / word, 2'b11 is illegal)
//   - byte-lane strobe width
//   - response-register state encoding and response payload struct
//   - helper to flag the illegal size encoding
// -----------------------------------------------------------------------------
package kay_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    localparam int STRB_W = 4;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } rsp_t;

    function automatic logic size_illegal(input logic [1:0] size);
        return size == SIZE_X;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for RV32 loads and stores.
// Ports:
//   lane        in   2   byte offset within the word (address bits [1:0])
//   size        in   2   access size (SIZE_B / SIZE_H / SIZE_W)
//   is_unsigned in   1   loads: 1 zero-extends, 0 sign-extends
//   wdata       in   32  right-aligned store data
//   rword       in   32  raw word read from the array
//   strobe      out  4   byte-lane write enables
//   wword       out  32  store data replicated into every lane position
//   rdata_ext   out  32  load data shifted down and extended
//   misalign    out  1   half on an odd address or word off a word boundary
// -----------------------------------------------------------------------------
module mem_lane_align
    import kay_mem_pkg::*;
(
    input  logic [1:0]        lane,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [31:0]       wdata,
    input  logic [31:0]       rword,
    output logic [STRB_W-1:0] strobe,
    output logic [31:0]       wword,
    output logic [31:0]       rdata_ext,
    output logic              misalign
);

    logic [31:0] shifted;

    // Bring the addressed byte/half down to bit 0 before extension.
    assign shifted = rword >> {lane, 3'b000};

    // NOTE: every output of a combinational block gets a default before the
    // case statement, so no path leaves a value unassigned and no latch forms.
    always_comb begin
        strobe    = '0;
        wword     = wdata;
        rdata_ext = '0;
        misalign  = 1'b0;
        case (size)
            SIZE_B: begin
                strobe    = 4'b0001 << lane;
                wword     = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                // An odd lane faults upstream, so the shifted-out strobe bit
                // for lane 3 never reaches the array.
                strobe    = 4'b0011 << lane;
                wword     = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
                misalign  = lane[0];
            end
            SIZE_W: begin
                strobe    = 4'b1111;
                wword     = wdata;
                rdata_ext = rword;
                misalign  = (lane != 2'b00);
            end
            default: begin
                strobe    = '0;
                wword     = wdata;
                rdata_ext = '0;
                misalign  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/byte_data_mem.sv
// -----------------------------------------------------------------------------
// byte_data_mem
// Byte-addressed single-port data memory behind a valid/ready request and
// response handshake. Supports RV32 byte/half/word loads and stores with
// byte-lane strobes, sign/zero extension and misalignment faulting. One
// response register (EMPTY/FULL) gives one-request-per-cycle throughput.
//
// Optional feature macro: DATAMEM_BOUNDS_CHECK_EN
//   defined   : byte addresses >= DEPTH_WORDS*4 fault (no write, RData = 0)
//   undefined : upper address bits ignored, addresses wrap modulo DEPTH_WORDS*4
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 4)
//   ADDR_W       request byte-address width
// Ports:
//   i_Clk           in   1       clock, rising edge
//   i_Rst           in   1       synchronous active-high reset
//   i_Req_Valid     in   1       request present
//   o_Req_Ready     out  1       request accepted when Valid && Ready
//   i_Req_Write     in   1       1 = store, 0 = load
//   i_Req_Addr      in   ADDR_W  byte address
//   i_Req_Size      in   2       00 byte, 01 half, 10 word, 11 faults
//   i_Req_Unsigned  in   1       loads: 1 zero-extend, 0 sign-extend
//   i_Req_WData     in   32      right-aligned store data
//   o_Rsp_Valid     out  1       response present
//   i_Rsp_Ready     in   1       response consumed when Valid && Ready
//   o_Rsp_RData     out  32      extended load data; 0 for stores/faults
//   o_Rsp_Fault     out  1       request faulted, no side effect
// -----------------------------------------------------------------------------
module byte_data_mem
    import kay_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Req_Valid,
    output logic              o_Req_Ready,
    input  logic              i_Req_Write,
    input  logic [ADDR_W-1:0] i_Req_Addr,
    input  logic [1:0]        i_Req_Size,
    input  logic              i_Req_Unsigned,
    input  logic [31:0]       i_Req_WData,
    output logic              o_Rsp_Valid,
    input  logic              i_Rsp_Ready,
    output logic [31:0]       o_Rsp_RData,
    output logic              o_Rsp_Fault
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]       mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  word_idx;
    logic [31:0]       rword;
    logic [STRB_W-1:0] strobe;
    logic [31:0]       wword;
    logic [31:0]       rdata_ext;
    logic              misalign;
    logic              size_bad;
    logic              out_of_range;
    logic              req_fault;
    logic              accept;

    rsp_state_e        state_q, state_d;
    rsp_t              rsp_q, rsp_d;

    // -------------------------------------------------------------------------
    // Address decode and lane steering
    // -------------------------------------------------------------------------
    assign word_idx = i_Req_Addr[IDX_W+1:2];

    // Asynchronous array read: the response register captures load data at the
    // accept edge, so a store at edge N is visible to a load accepted at N+1.
    assign rword = mem[word_idx];

    mem_lane_align u_align (
        .lane        (i_Req_Addr[1:0]),
        .size        (i_Req_Size),
        .is_unsigned (i_Req_Unsigned),
        .wdata       (i_Req_WData),
        .rword       (rword),
        .strobe      (strobe),
        .wword       (wword),
        .rdata_ext   (rdata_ext),
        .misalign    (misalign)
    );

    assign size_bad = size_illegal(i_Req_Size);

`ifdef DATAMEM_BOUNDS_CHECK_EN
    // One extra bit keeps the limit representable even when DEPTH_WORDS*4
    // equals 2**ADDR_W; the comparison spans the full address width.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH_WORDS * 4);

    assign out_of_range = ({1'b0, i_Req_Addr} >= ADDR_LIMIT);
`else
    // Upper address bits deliberately ignored: addresses alias modulo the size.
    logic unused_upper_addr;

    assign unused_upper_addr = ^i_Req_Addr[ADDR_W-1:IDX_W+2];
    assign out_of_range      = 1'b0;
`endif

    assign req_fault = misalign | size_bad | out_of_range;

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    // Combinational path from i_Rsp_Ready lets a consumed response be replaced
    // in the same cycle, sustaining one request per cycle.
    assign o_Req_Ready = !i_Rst && (!o_Rsp_Valid || i_Rsp_Ready);
    assign accept      = i_Req_Valid && o_Req_Ready;

    // -------------------------------------------------------------------------
    // Array write (per-byte enables)
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; clearing it would prevent RAM
    // inference, and its contents are undefined until written anyway.
    always_ff @(posedge i_Clk) begin
        if (accept && i_Req_Write && !req_fault) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strobe[b]) begin
                    mem[word_idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response register: next-state / next-payload
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rsp_d   = rsp_q;
        case (state_q)
            RSP_EMPTY: begin
                if (accept) begin
                    state_d = RSP_FULL;
                end
            end
            RSP_FULL: begin
                // An accept here implies i_Rsp_Ready, so the old response
                // leaves as the new one arrives.
                if (accept) begin
                    state_d = RSP_FULL;
                end else if (i_Rsp_Ready) begin
                    state_d = RSP_EMPTY;
                end
            end
            default: begin
                state_d = RSP_EMPTY;
            end
        endcase

        if (accept) begin
            rsp_d.fault = req_fault;
            rsp_d.rdata = (req_fault || i_Req_Write) ? 32'h0 : rdata_ext;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of every other register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= RSP_EMPTY;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            rsp_q   <= rsp_d;
        end
    end

    assign o_Rsp_Valid = (state_q == RSP_FULL);
    assign o_Rsp_RData = rsp_q.rdata;
    assign o_Rsp_Fault = rsp_q.fault;

endmodule

// File: tb/tb_byte_data_mem.sv
// -----------------------------------------------------------------------------
// tb_byte_data_mem
// Self-checking bench for byte_data_mem: reset checks, a table of directed
// load/store vectors, hand-written backpressure / streaming / mid-reset
// sequences, and randomized traffic compared against a byte-array model.
// -----------------------------------------------------------------------------
module tb_byte_data_mem;

    localparam int DEPTH     = 1024;
    localparam int MEM_BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    byte_data_mem #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
        .i_Clk          (clk),
        .i_Rst          (rst),
        .i_Req_Valid    (req_valid),
        .o_Req_Ready    (req_ready),
        .i_Req_Write    (req_write),
        .i_Req_Addr     (req_addr),
        .i_Req_Size     (req_size),
        .i_Req_Unsigned (req_unsigned),
        .i_Req_WData    (req_wdata),
        .o_Rsp_Valid    (rsp_valid),
        .i_Rsp_Ready    (rsp_ready),
        .o_Rsp_RData    (rsp_rdata),
        .o_Rsp_Fault    (rsp_fault)
    );

    // ---------------------------------------------------------------- checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------- reference model
    // Little-endian byte array; faults from size/alignment/range rules.
    logic [7:0] mb [MEM_BYTES];

    function automatic void model_access(input logic wr, input logic [31:0] addr,
                                         input logic [1:0] size, input logic uns,
                                         input logic [31:0] wdata,
                                         output logic [31:0] rdata, output logic flt);
        int unsigned nbytes;
        int unsigned base;
        logic [31:0] v;
        nbytes = 1 << size;
        flt    = (size == 2'b11) || ((addr % nbytes) != 0);
`ifdef DATAMEM_BOUNDS_CHECK_EN
        if (addr >= MEM_BYTES) flt = 1'b1;
`endif
        rdata = 32'h0;
        if (flt) return;
        base = addr % MEM_BYTES;
        if (wr) begin
            for (int k = 0; k < int'(nbytes); k++) mb[base + k] = 8'(wdata >> (8 * k));
        end else begin
            v = 32'h0;
            for (int k = 0; k < int'(nbytes); k++) v = v | (32'(mb[base + k]) << (8 * k));
            if (!uns && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~((32'd1 << (8 * nbytes)) - 1);
            rdata = v;
        end
    endfunction

    // ---------------------------------------------------------------- driver
    // Entered and left at posedge+1; response sampled one step after the
    // accept edge, with i_Rsp_Ready held high.
    task automatic xact(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic flt, output logic vld);
        int n;
        req_write = wr; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        req_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        n = 0;
        while (!req_ready && n < 16) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL xact_accept: req_ready got 0 expected 1");
            req_valid = 1'b0; rdata = 'x; flt = 1'bx; vld = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rdata = rsp_rdata; flt = rsp_fault; vld = rsp_valid;
    endtask

    task automatic run_model(input string name, input logic wr, input logic [31:0] addr,
                             input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        logic [31:0] exp_d, got_d;
        logic        exp_f, got_f, got_v;
        model_access(wr, addr, size, uns, wdata, exp_d, exp_f);
        xact(wr, addr, size, uns, wdata, got_d, got_f, got_v);
        check({name, "_valid"}, 32'(got_v), 32'd1);
        check({name, "_rdata"}, got_d, exp_d);
        check({name, "_fault"}, 32'(got_f), 32'(exp_f));
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        string       name;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic wr, input logic [31:0] addr,
                                input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_fault);
        vec_t v;
        v.name = name; v.wr = wr; v.addr = addr; v.size = size; v.uns = uns;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_fault = exp_fault;
        return v;
    endfunction

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] d, exp_d, got_d;
        logic        f, got_f, got_v;
        logic [31:0] stream_exp_d [8];
        logic        stream_exp_f [8];
        logic        stream_wr;
        logic [31:0] stream_addr, stream_wdata;
        logic [1:0]  stream_size;
        logic        stream_uns;
        logic [31:0] pend_data;

        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_write = 1'b0;
        req_addr = '0; req_size = 2'b00; req_unsigned = 1'b0; req_wdata = '0;

        // ------------------------------------------------------------- reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // ---------------------------------------------------------- prefill
        for (int w = 0; w < 128; w++) run_model("prefill", 1'b1, 32'(w * 4), 2'b10, 1'b0, $urandom);

        // ------------------------------------------------------------ table
        vecs.push_back(mk("st_w_10",    1, 32'h10, 2'b10, 0, 32'h8899AABB, 32'h0,        0));
        vecs.push_back(mk("ld_b_13_s",  0, 32'h13, 2'b00, 0, 32'h0,        32'hFFFFFF88, 0));
        vecs.push_back(mk("ld_b_13_u",  0, 32'h13, 2'b00, 1, 32'h0,        32'h00000088, 0));
        vecs.push_back(mk("ld_h_12_s",  0, 32'h12, 2'b01, 0, 32'h0,        32'hFFFF8899, 0));
        vecs.push_back(mk("ld_b_12_u",  0, 32'h12, 2'b00, 1, 32'h0,        32'h00000099, 0));
        vecs.push_back(mk("ld_h_11",    0, 32'h11, 2'b01, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk("st_w_20",    1, 32'h20, 2'b10, 0, 32'h11223344, 32'h0,        0));
        vecs.push_back(mk("st_b_21",    1, 32'h21, 2'b00, 0, 32'hFFFFFF5A, 32'h0,        0));
        vecs.push_back(mk("ld_w_20",    0, 32'h20, 2'b10, 0, 32'h0,        32'h11225A44, 0));
        vecs.push_back(mk("st_w_30",    1, 32'h30, 2'b10, 0, 32'hCAFEF00D, 32'h0,        0));
        vecs.push_back(mk("st_h_31",    1, 32'h31, 2'b01, 0, 32'h00001234, 32'h0,        1));
        vecs.push_back(mk("ld_w_30_a",  0, 32'h30, 2'b10, 0, 32'h0,        32'hCAFEF00D, 0));
        vecs.push_back(mk("st_x_30",    1, 32'h30, 2'b11, 0, 32'h55555555, 32'h0,        1));
        vecs.push_back(mk("ld_w_30_b",  0, 32'h30, 2'b10, 0, 32'h0,        32'hCAFEF00D, 0));
        vecs.push_back(mk("ld_x_30",    0, 32'h30, 2'b11, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk("ld_w_32",    0, 32'h32, 2'b10, 0, 32'h0,        32'h0,        1));
        vecs.push_back(mk("ld_h_32_u",  0, 32'h32, 2'b01, 1, 32'h0,        32'h0000CAFE, 0));
        vecs.push_back(mk("st_h_32",    1, 32'h32, 2'b01, 0, 32'h7777BEEF, 32'h0,        0));
        vecs.push_back(mk("ld_w_30_c",  0, 32'h30, 2'b10, 1, 32'h0,        32'hBEEFF00D, 0));
        vecs.push_back(mk("st_w_0",     1, 32'h0,  2'b10, 0, 32'h0BADF00D, 32'h0,        0));
`ifdef DATAMEM_BOUNDS_CHECK_EN
        vecs.push_back(mk("st_w_1000",  1, 32'h1000, 2'b10, 0, 32'h13579BDF, 32'h0,      1));
        vecs.push_back(mk("ld_w_0",     0, 32'h0,    2'b10, 0, 32'h0,        32'h0BADF00D, 0));
        vecs.push_back(mk("ld_w_1000",  0, 32'h1000, 2'b10, 0, 32'h0,        32'h0,      1));
`else
        vecs.push_back(mk("st_w_1000",  1, 32'h1000, 2'b10, 0, 32'h13579BDF, 32'h0,      0));
        vecs.push_back(mk("ld_w_0",     0, 32'h0,    2'b10, 0, 32'h0,        32'h13579BDF, 0));
        vecs.push_back(mk("ld_w_1000",  0, 32'h1000, 2'b10, 0, 32'h0,        32'h13579BDF, 0));
`endif

        foreach (vecs[i]) begin
            // Keep the model in step with the directed traffic.
            model_access(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, exp_d, f);
            xact(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, got_d, got_f, got_v);
            check({vecs[i].name, "_valid"}, 32'(got_v), 32'd1);
            check({vecs[i].name, "_rdata"}, got_d, vecs[i].exp_rdata);
            check({vecs[i].name, "_fault"}, 32'(got_f), 32'(vecs[i].exp_fault));
        end

        // ------------------------------------------------------ backpressure
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drain_valid", 32'(rsp_valid), 32'd0);
        req_write = 1'b0; req_addr = 32'h20; req_size = 2'b10; req_unsigned = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        #1;
        check("bp_first_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        // Next request waits while the response is not consumed.
        req_addr = 32'h10;
        for (int c = 0; c < 3; c++) begin
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata", rsp_rdata, 32'h11225A44);
            check("bp_rsp_fault", 32'(rsp_fault), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_second_valid", 32'(rsp_valid), 32'd1);
        check("bp_second_rdata", rsp_rdata, 32'h8899AABB);

        // --------------------------------------------------------- streaming
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            stream_wr    = 1'($urandom_range(0, 1));
            stream_addr  = 32'($urandom_range(64, 511));
            stream_size  = 2'($urandom_range(0, 2));
            stream_uns   = 1'($urandom_range(0, 1));
            stream_wdata = $urandom;
            model_access(stream_wr, stream_addr, stream_size, stream_uns, stream_wdata,
                         stream_exp_d[i], stream_exp_f[i]);
            req_write = stream_wr; req_addr = stream_addr; req_size = stream_size;
            req_unsigned = stream_uns; req_wdata = stream_wdata; req_valid = 1'b1;
            #1;
            check("stream_req_ready", 32'(req_ready), 32'd1);
            @(posedge clk); #1;
            check("stream_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stream_rsp_rdata", rsp_rdata, stream_exp_d[i]);
            check("stream_rsp_fault", 32'(rsp_fault), 32'(stream_exp_f[i]));
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("stream_drained", 32'(rsp_valid), 32'd0);

        // ------------------------------------------------------------ random
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 511));
            if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_F000);
            run_model("rand", 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom);
        end

        // ------------------------------------------------- reset mid-operation
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        model_access(1'b0, 32'h40, 2'b10, 1'b0, 32'h0, pend_data, f);
        req_write = 1'b0; req_addr = 32'h40; req_size = 2'b10; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        check("mr_pending_valid", 32'(rsp_valid), 32'd1);
        check("mr_pending_rdata", rsp_rdata, pend_data);
        rst = 1'b1;
        req_write = 1'b1; req_addr = 32'h44; req_size = 2'b10; req_wdata = 32'hDEADBEEF;
        rsp_ready = 1'b1;
        #1;
        check("mr_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mr_rsp_rdata", rsp_rdata, 32'h0);
        check("mr_rsp_fault", 32'(rsp_fault), 32'd0);
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        run_model("mr_no_write", 1'b0, 32'h44, 2'b10, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_data_mem.md
# byte_data_mem

Byte-addressed, single-port data memory with a valid/ready request/response handshake. It supports RV32 load/store sizes (byte, half, word) with byte-lane write strobes, sign/zero extension on loads and misalignment faulting. It replaces the word-indexed data memory behind the core's MEM stage: the core issues one request per accepted handshake and receives exactly one response per request.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two ≥ 4.
- ADDR_W, 32: request byte-address width.

- i_Clk  input  1  system clock, all logic on rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_Req_Valid  input  1  request present.
- o_Req_Ready  output  1  request accepted on the edge when Valid && Ready.
- i_Req_Write  input  1  1 = store, 0 = load.
- i_Req_Addr  input  ADDR_W  byte address.
- i_Req_Size  input  2  00 byte, 01 half, 10 word; 11 is illegal and faults.
- i_Req_Unsigned  input  1  loads only: 1 zero-extends, 0 sign-extends.
- i_Req_WData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- o_Rsp_Valid  output  1  response present.
- i_Rsp_Ready  input  1  response consumed on the edge when Valid && Ready.
- o_Rsp_RData  output  32  load result, extended; 0 for stores and faults.
- o_Rsp_Fault  output  1  request faulted; no memory side effect.

## Operation
- Word index is i_Req_Addr[log2(DEPTH_WORDS)+1:2]; lane is i_Req_Addr[1:0].
- Stores: WData is replicated to the addressed lanes; the strobe is 0001<<lane (byte), 0011<<lane (half), or 1111 (word). Only strobed bytes change.
- Loads: read the full word, shift right by lane*8, keep 8/16/32 bits, then extend per i_Req_Unsigned. Word loads ignore i_Req_Unsigned.
- Fault conditions:
  - half with Addr[0] = 1;
  - word with Addr[1:0] ≠ 00;
  - Size = 11;
  - out of range (see Configuration).
- A faulting request writes nothing and responds with Fault = 1 and RData = 0.
- Every accepted request, load or store, produces exactly one response. Store responses have RData = 0.
- Control: the output response register is the only state besides the array. The states are EMPTY (Rsp_Valid = 0) and FULL (Rsp_Valid = 1).
  - EMPTY → FULL on accept.
  - FULL → EMPTY on Rsp_Ready without a new accept.
  - FULL → FULL when Rsp_Ready and accept occur in the same cycle (response replaced).
- o_Req_Ready = !i_Rst && (!o_Rsp_Valid || i_Rsp_Ready). It is combinational from i_Rsp_Ready, so back-to-back throughput is one request per cycle.
- While FULL and i_Rsp_Ready = 0, all response outputs hold stable.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: o_Rsp_Valid = 0, o_Rsp_RData = 0, o_Rsp_Fault = 0, o_Req_Ready = 0 while i_Rst = 1.
- Reset mid-operation: a pending response is dropped. A request presented in the reset cycle is not accepted, and no write occurs.
- Latency: a request accepted at edge N has its response valid after edge N (visible in cycle N+1). The store's array update is also complete at edge N.
- Load-after-store to the same word in consecutive accepts returns the new data. There is no hazard because the array is written and read at distinct edges.
- Handshake rules:
  - Requester must hold all i_Req_* stable while Valid && !Ready.
  - Responder may assert i_Rsp_Ready at any time.

## Configuration
- DATAMEM_BOUNDS_CHECK_EN defined:
  - Addr ≥ DEPTH_WORDS*4 faults (Fault = 1, no write, RData = 0).
  - Upper address bits are compared in full ADDR_W width.
- Not defined:
  - Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Only alignment and Size = 11 fault.

## Structure
- Shared package kay_mem_pkg:
  - size encodings SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10;
  - strobe width constant 4.
- Sub-module mem_lane_align (combinational):
  - inputs: Addr[1:0], Size, Unsigned, WData, raw read word;
  - outputs: strobe[3:0], lane-replicated write word, extended load data, misalign flag.
- The top level holds the array (per-byte write enables), the response register, the bounds check and the handshake.

## Test plan
- Reset then idle → Rsp_Valid = 0, RData = 0, Fault = 0, Req_Ready = 0 during reset and 1 after.
- Store word 0x8899AABB @0x10, then load byte @0x13 signed → RData = 0xFFFFFF88. Load byte @0x13 unsigned → 0x00000088. Load half @0x12 signed → 0xFFFF8899.
- Store byte 0x5A @0x21 over word 0x11223344 @0x20, then load word @0x20 → 0x11225A44.
- Half store @0x31 → Fault = 1, RData = 0; a later word load @0x30 returns the prior contents unchanged. Repeat with Size = 11 → Fault = 1.
- Hold i_Rsp_Ready = 0 for 3 cycles after a load → Req_Ready = 0 and the response is stable. Then hold Rsp_Ready = 1 with Valid continuous for 8 requests → 8 responses in 8 consecutive cycles, in order.
- With DATAMEM_BOUNDS_CHECK_EN and DEPTH_WORDS = 1024, store @0x1000 → Fault = 1 and no write. Without the macro, the same store aliases to @0x0000, and a load @0x0 returns the stored value.
